// File: rtl/irq_halt_controller_if.sv
// irq_halt_controller_if: CPU I/O write bus (address, strobe, byte enables, data) into the halt controller.
interface irq_halt_controller_if;
    logic [11:0] io_addr;
    logic        io_write;
    logic [3:0]  io_be;
    logic [31:0] bus_wdata;
    modport master (output io_addr, io_write, io_be, bus_wdata);
    modport slave  (input  io_addr, io_write, io_be, bus_wdata);
endinterface

// File: rtl/irq_halt_controller.sv
// irq_halt_controller: IF ack pulses, IME bit and HALT/STOP power FSM stalling the CPU until an enabled IRQ is pending.
module irq_halt_controller #(
    parameter logic [9:0]  IO_IE_IF_WORD   = 10'h080,
    parameter logic [9:0]  IO_IME_WORD     = 10'h082,
    parameter logic [9:0]  IO_HALTCNT_WORD = 10'h0C0,
    parameter logic [13:0] STOP_WAKE_MASK  = 14'h3080
) (
    input  logic                  clock,
    input  logic                  reset_n,
    irq_halt_controller_if.slave  bus,
    inout  wire  [31:0]           io_reg_rdata,
    input  logic [15:0]           reg_IE,
    input  logic [15:0]           reg_IF,
    output logic [15:0]           reg_ACK,
    output logic                  ime,
    input  logic                  cpu_busy,
    input  logic                  dma_active,
    output logic                  cpu_halt,
    output logic                  sys_stop,
    output logic [1:0]            pwr_state,
    output logic [31:0]           halt_cycles
);
    typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, HALTED = 2'd2, WAKE = 2'd3} state_t;
    state_t     state;
    logic [9:0] word;
    logic       stop_flag;
    logic       wake_h;
    logic       wake_s;
    logic       wake;
    logic       ack_wr;
    logic       ime_wr;
    logic       halt_req;
    logic       unused;
    assign word     = bus.io_addr[11:2];
    assign ack_wr   = bus.io_write && word == IO_IE_IF_WORD;
    assign ime_wr   = bus.io_write && word == IO_IME_WORD && bus.io_be[0];
    assign halt_req = bus.io_write && word == IO_HALTCNT_WORD && bus.io_be[1];
    // Wake ignores IME: HALT only waits for a pending enabled source.
    assign wake_h   = |(reg_IE[13:0] & reg_IF[13:0]);
    assign wake_s   = |(reg_IE[13:0] & reg_IF[13:0] & STOP_WAKE_MASK);
    assign wake     = stop_flag ? wake_s : wake_h;
    assign pwr_state    = state;
    assign io_reg_rdata = (word == IO_IME_WORD) ? {31'b0, ime} : 32'bz;
    assign unused = ^{bus.io_addr[1:0], bus.bus_wdata[31:30], bus.bus_wdata[14:1],
                      reg_IE[15:14], reg_IF[15:14]};
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_ACK <= '0;
            ime     <= 1'b0;
        end else begin
            reg_ACK <= ack_wr ? {2'b0, bus.io_be[3] ? bus.bus_wdata[29:24] : 6'b0,
                                       bus.io_be[2] ? bus.bus_wdata[23:16] : 8'b0} : 16'b0;
            if (ime_wr)
                ime <= bus.bus_wdata[0];
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            stop_flag <= 1'b0;
            cpu_halt  <= 1'b0;
            sys_stop  <= 1'b0;
        end else begin
            case (state)
                RUN: if (halt_req) begin
                    state     <= PEND;
                    stop_flag <= bus.bus_wdata[15];
                end
                PEND: if (wake) begin
                    state     <= RUN;
                    stop_flag <= 1'b0;
                end else if (!cpu_busy && !dma_active) begin
                    state    <= HALTED;
                    cpu_halt <= 1'b1;
                    sys_stop <= stop_flag;
                end
                HALTED: if (wake) begin
                    state    <= WAKE;
                    sys_stop <= 1'b0;
                end
                WAKE: begin
                    state     <= RUN;
                    cpu_halt  <= 1'b0;
                    stop_flag <= 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            halt_cycles <= '0;
        else if (cpu_halt && halt_cycles != 32'hFFFF_FFFF)
            halt_cycles <= halt_cycles + 32'd1;
    end
endmodule

// File: tb/tb_irq_halt_controller.sv
// tb_irq_halt_controller: directed checks of ack pulses, IME, HALT/STOP sequencing, PEND hold/abort and async reset.
module tb_irq_halt_controller;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] reg_IE = '0;
    logic [15:0] reg_IF = '0;
    logic        cpu_busy = 1'b0;
    logic        dma_active = 1'b0;
    wire  [31:0] io_reg_rdata;
    logic [15:0] reg_ACK;
    logic        ime;
    logic        cpu_halt;
    logic        sys_stop;
    logic [1:0]  pwr_state;
    logic [31:0] halt_cycles;
    int checks = 0;
    int failures = 0;

    irq_halt_controller_if bus ();

    irq_halt_controller dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .io_reg_rdata(io_reg_rdata),
        .reg_IE(reg_IE), .reg_IF(reg_IF), .reg_ACK(reg_ACK), .ime(ime),
        .cpu_busy(cpu_busy), .dma_active(dma_active), .cpu_halt(cpu_halt),
        .sys_stop(sys_stop), .pwr_state(pwr_state), .halt_cycles(halt_cycles)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.io_addr = a;
        bus.bus_wdata = d;
        bus.io_be = be;
        bus.io_write = 1'b1;
        tick();
        bus.io_write = 1'b0;
    endtask

    initial begin
        bus.io_addr = 12'h000;
        bus.io_write = 1'b0;
        bus.io_be = 4'h0;
        bus.bus_wdata = '0;
        #2;
        chk("rst_ack", 32'(reg_ACK), 32'h0);
        chk("rst_ime", 32'(ime), 32'h0);
        chk("rst_halt", 32'(cpu_halt), 32'h0);
        chk("rst_state", 32'(pwr_state), 32'h0);
        chk("rst_hc", halt_cycles, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        wr(12'h200, 32'h0005_0000, 4'b0100);
        chk("ack_lo", 32'(reg_ACK), 32'h0005);
        tick();
        chk("ack_lo_clr", 32'(reg_ACK), 32'h0);
        wr(12'h200, 32'h2000_0000, 4'b1000);
        chk("ack_hi", 32'(reg_ACK), 32'h2000);
        wr(12'h200, 32'hFFFF_FFFF, 4'b0011);
        chk("ack_ie_ignored", 32'(reg_ACK), 32'h0);
        bus.io_addr = 12'h200; bus.io_be = 4'b1100; bus.io_write = 1'b1;
        bus.bus_wdata = 32'hFFFF_0000;
        tick();
        chk("ack_b2b_a", 32'(reg_ACK), 32'h3FFF);
        bus.bus_wdata = 32'h0102_0000;
        tick();
        bus.io_write = 1'b0;
        chk("ack_b2b_b", 32'(reg_ACK), 32'h0102);
        tick();
        chk("ack_b2b_clr", 32'(reg_ACK), 32'h0);

        wr(12'h208, 32'h0000_0001, 4'b0001);
        chk("ime_set", 32'(ime), 32'h1);
        chk("ime_read", io_reg_rdata, 32'h1);
        wr(12'h208, 32'h0000_0000, 4'b0010);
        chk("ime_be_ignored", 32'(ime), 32'h1);
        bus.io_addr = 12'h000;
        #1;
        checks++;
        assert (io_reg_rdata === 32'bz) else begin
            failures++;
            $error("FAIL rdata_hiz observed=%h expected=zzzzzzzz", io_reg_rdata);
        end

        reg_IE = 16'h0001;
        reg_IF = 16'h0000;
        wr(12'h300, 32'h0000_0000, 4'b0010);
        chk("halt_pend", 32'(pwr_state), 32'h1);
        chk("halt_pend_nohalt", 32'(cpu_halt), 32'h0);
        tick();
        chk("halt_on", 32'(cpu_halt), 32'h1);
        chk("halt_state", 32'(pwr_state), 32'h2);
        chk("halt_nostop", 32'(sys_stop), 32'h0);
        wr(12'h300, 32'h0000_8000, 4'b0010);
        chk("halt_req_ignored", 32'(sys_stop), 32'h0);
        for (int i = 0; i < 99; i++) tick();
        chk("halt_hc100", halt_cycles, 32'd100);
        reg_IF = 16'h0001;
        tick();
        chk("wake_state", 32'(pwr_state), 32'h3);
        chk("wake_halt_held", 32'(cpu_halt), 32'h1);
        tick();
        chk("wake_run", 32'(pwr_state), 32'h0);
        chk("wake_halt_off", 32'(cpu_halt), 32'h0);
        chk("halt_hc102", halt_cycles, 32'd102);
        reg_IF = 16'h0000;
        tick();
        chk("hc_hold", halt_cycles, 32'd102);

        reg_IE = 16'h1001;
        wr(12'h300, 32'h0000_8000, 4'b0010);
        tick();
        chk("stop_sys", 32'(sys_stop), 32'h1);
        chk("stop_halt", 32'(cpu_halt), 32'h1);
        reg_IF = 16'h0001;
        tick(); tick();
        chk("stop_vblank_state", 32'(pwr_state), 32'h2);
        chk("stop_vblank_sys", 32'(sys_stop), 32'h1);
        reg_IF = 16'h1000;
        tick();
        chk("stop_wake_state", 32'(pwr_state), 32'h3);
        chk("stop_wake_sys", 32'(sys_stop), 32'h0);
        tick();
        chk("stop_run", 32'(pwr_state), 32'h0);
        chk("stop_run_halt", 32'(cpu_halt), 32'h0);
        reg_IF = 16'h0000;

        reg_IE = 16'h0001;
        cpu_busy = 1'b1;
        wr(12'h300, 32'h0000_0000, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_pend", 32'(pwr_state), 32'h1);
            chk("busy_nohalt", 32'(cpu_halt), 32'h0);
        end
        cpu_busy = 1'b0;
        tick();
        chk("busy_halted", 32'(pwr_state), 32'h2);
        reg_IF = 16'h0001;
        tick(); tick();
        chk("busy_back_run", 32'(pwr_state), 32'h0);

        wr(12'h300, 32'h0000_0000, 4'b0010);
        chk("abort_pend", 32'(pwr_state), 32'h1);
        tick();
        chk("abort_run", 32'(pwr_state), 32'h0);
        chk("abort_nohalt", 32'(cpu_halt), 32'h0);
        tick();
        chk("abort_stay_run", 32'(pwr_state), 32'h0);
        reg_IF = 16'h0000;

        wr(12'h300, 32'h0000_0000, 4'b0010);
        tick(); tick();
        chk("rst_mid_pre", 32'(cpu_halt), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_halt", 32'(cpu_halt), 32'h0);
        chk("rst_mid_state", 32'(pwr_state), 32'h0);
        chk("rst_mid_hc", halt_cycles, 32'h0);
        chk("rst_mid_ime", 32'(ime), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_after_state", 32'(pwr_state), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
